// File: rtl/ldq_ret_ctrl.sv
// ldq_ret_ctrl: in-order retirement of the 32-entry load-buffer ID pool.
// Define LDQ_RET_CHECK_EN to build the sticky protocol-error checker.
module ldq_ret_ctrl #(
    parameter int LDQ_DEPTH = 32,
    parameter int ID_W      = 5,
    parameter int RET_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_csr_trap_flush,
    input  logic             i_mis_flush,
    input  logic [ID_W-1:0]  i_mis_ld_id,
    input  logic [RET_W-1:0] i_alloc_vld,
    input  logic [ID_W-1:0]  i_alloc_base_id,
    input  logic [1:0]       i_cmt_vld,
    input  logic [ID_W-1:0]  i_cmt_id_0,
    input  logic [ID_W-1:0]  i_cmt_id_1,
    output logic [RET_W-1:0] o_ret_vld,
    output logic [ID_W-1:0]  o_ret_head_id,
    output logic [ID_W:0]    o_ldq_cnt,
    output logic             o_ret_err
);
    localparam int CW = $clog2(RET_W + 1);

    logic [LDQ_DEPTH-1:0] alloc_q, alloc_d;
    logic [LDQ_DEPTH-1:0] done_q, done_d;
    logic [ID_W-1:0]      head_q, head_d;
    logic [ID_W-1:0]      tail_q, tail_d;
    logic [ID_W-1:0]      ret_head_q, ret_head_d;
    logic [ID_W:0]        cnt_q, cnt_d;
    logic [RET_W-1:0]     ret_vld_q, ret_vld_d;

    logic [CW-1:0]   ret_k, alloc_n;
    logic [ID_W-1:0] idx, off, mis_off;
    logic [ID_W:0]   sq_cnt;
    logic            run, mis_en;

    always_comb begin
        alloc_d    = alloc_q;
        done_d     = done_q;
        head_d     = head_q;
        tail_d     = tail_q;
        cnt_d      = cnt_q;
        ret_vld_d  = '0;
        ret_head_d = head_q;
        ret_k      = '0;
        alloc_n    = '0;
        run        = 1'b1;
        idx        = '0;
        off        = '0;
        sq_cnt     = '0;
        mis_off    = i_mis_ld_id - head_q;
        mis_en     = i_mis_flush && (i_mis_ld_id != tail_q);

        if (i_cmt_vld[0] && alloc_q[i_cmt_id_0]) done_d[i_cmt_id_0] = 1'b1;
        if (i_cmt_vld[1] && alloc_q[i_cmt_id_1]) done_d[i_cmt_id_1] = 1'b1;

        // Retire the unbroken committed run at the head, at most RET_W wide.
        for (int j = 0; j < RET_W; j++) begin
            idx = head_q + ID_W'(j);
            if (run && alloc_q[idx] && done_q[idx]) begin
                ret_vld_d[j] = 1'b1;
                ret_k        = ret_k + CW'(1);
                alloc_d[idx] = 1'b0;
                done_d[idx]  = 1'b0;
            end else begin
                run = 1'b0;
            end
        end
        head_d = head_q + ID_W'(ret_k);

        if (mis_en) begin
            if ({1'b0, mis_off} < cnt_q) sq_cnt = cnt_q - {1'b0, mis_off};
            for (int i = 0; i < LDQ_DEPTH; i++) begin
                off = ID_W'(i) - head_q;
                if (off >= mis_off && {1'b0, off} < cnt_q) begin
                    alloc_d[i] = 1'b0;
                    done_d[i]  = 1'b0;
                end
            end
        end

        if (i_mis_flush) begin
            tail_d = i_mis_ld_id;
        end else begin
            for (int k = 0; k < RET_W; k++) begin
                if (i_alloc_vld[k]) begin
                    idx          = i_alloc_base_id + ID_W'(alloc_n);
                    alloc_d[idx] = 1'b1;
                    done_d[idx]  = 1'b0;
                    alloc_n      = alloc_n + CW'(1);
                end
            end
            tail_d = tail_q + ID_W'(alloc_n);
        end

        cnt_d = cnt_q + (ID_W+1)'(alloc_n) - (ID_W+1)'(ret_k) - sq_cnt;

        if (i_csr_trap_flush) begin
            alloc_d    = '0;
            done_d     = '0;
            head_d     = '0;
            tail_d     = '0;
            cnt_d      = '0;
            ret_vld_d  = '0;
            ret_head_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alloc_q    <= '0;
            done_q     <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            cnt_q      <= '0;
            ret_vld_q  <= '0;
            ret_head_q <= '0;
        end else begin
            alloc_q    <= alloc_d;
            done_q     <= done_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            cnt_q      <= cnt_d;
            ret_vld_q  <= ret_vld_d;
            ret_head_q <= ret_head_d;
        end
    end

    assign o_ret_vld     = ret_vld_q;
    assign o_ret_head_id = ret_head_q;
    assign o_ldq_cnt     = cnt_q;

`ifdef LDQ_RET_CHECK_EN
    logic            err_q, err_d, bad;
    logic [ID_W-1:0] aid;
    logic [CW-1:0]   an;

    always_comb begin
        bad = (i_cmt_vld[0] && !alloc_q[i_cmt_id_0]) ||
              (i_cmt_vld[1] && !alloc_q[i_cmt_id_1]);
        an  = '0;
        aid = '0;
        if (!i_mis_flush) begin
            for (int k = 0; k < RET_W; k++) begin
                if (i_alloc_vld[k]) begin
                    aid = i_alloc_base_id + ID_W'(an);
                    if (alloc_q[aid]) bad = 1'b1;
                    an = an + CW'(1);
                end
            end
            if (({1'b0, cnt_q} + (ID_W+2)'(an)) > (ID_W+2)'(LDQ_DEPTH)) bad = 1'b1;
        end
        err_d = err_q | (bad & ~i_csr_trap_flush);
    end

    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign o_ret_err = err_q;
`else
    assign o_ret_err = 1'b0;
`endif

endmodule

// File: tb/tb_ldq_ret_ctrl.sv
// tb_ldq_ret_ctrl: directed bench for the load-ID retirement controller.
// Checks retire pulses, wrap, rollback, trap flush and the error flag.
module tb_ldq_ret_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       i_csr_trap_flush;
    logic       i_mis_flush;
    logic [4:0] i_mis_ld_id;
    logic [3:0] i_alloc_vld;
    logic [4:0] i_alloc_base_id;
    logic [1:0] i_cmt_vld;
    logic [4:0] i_cmt_id_0;
    logic [4:0] i_cmt_id_1;
    logic [3:0] o_ret_vld;
    logic [4:0] o_ret_head_id;
    logic [5:0] o_ldq_cnt;
    logic       o_ret_err;

    int checks = 0;
    int errors = 0;

    ldq_ret_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .i_csr_trap_flush (i_csr_trap_flush),
        .i_mis_flush      (i_mis_flush),
        .i_mis_ld_id      (i_mis_ld_id),
        .i_alloc_vld      (i_alloc_vld),
        .i_alloc_base_id  (i_alloc_base_id),
        .i_cmt_vld        (i_cmt_vld),
        .i_cmt_id_0       (i_cmt_id_0),
        .i_cmt_id_1       (i_cmt_id_1),
        .o_ret_vld        (o_ret_vld),
        .o_ret_head_id    (o_ret_head_id),
        .o_ldq_cnt        (o_ldq_cnt),
        .o_ret_err        (o_ret_err)
    );

    always #5 clk = ~clk;

    task automatic idle();
        rst              = 1'b0;
        i_csr_trap_flush = 1'b0;
        i_mis_flush      = 1'b0;
        i_mis_ld_id      = '0;
        i_alloc_vld      = '0;
        i_alloc_base_id  = '0;
        i_cmt_vld        = '0;
        i_cmt_id_0       = '0;
        i_cmt_id_1       = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alloc(input logic [4:0] base, input logic [3:0] vld);
        i_alloc_base_id = base;
        i_alloc_vld     = vld;
    endtask

    task automatic commit(input logic [1:0] vld, input logic [4:0] a, input logic [4:0] b);
        i_cmt_vld  = vld;
        i_cmt_id_0 = a;
        i_cmt_id_1 = b;
    endtask

    // Allocate 2 or 4 IDs at base, commit them in pairs, let them retire.
    task automatic batch(input logic [4:0] b, input bit four);
        alloc(b, four ? 4'b1111 : 4'b0011);
        tick();
        idle();
        commit(2'b11, b, b + 5'd1);
        tick();
        idle();
        if (four) begin
            commit(2'b11, b + 5'd2, b + 5'd3);
            tick();
            idle();
        end
        tick();
        tick();
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (o_ldq_cnt !== 6'd0) begin
            errors++;
            $display("FAIL reset_cnt got %0d exp 0", o_ldq_cnt);
        end
        checks++;
        if (o_ret_vld !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ret_vld got %b exp 0000", o_ret_vld);
        end
        checks++;
        if (o_ret_head_id !== 5'd0) begin
            errors++;
            $display("FAIL reset_head got %0d exp 0", o_ret_head_id);
        end
        checks++;
        if (o_ret_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_err got %b exp 0", o_ret_err);
        end
    endtask

    task automatic test_alloc();
        alloc(5'd0, 4'b1111);
        tick();
        idle();
        checks++;
        if (o_ldq_cnt !== 6'd4) begin
            errors++;
            $display("FAIL alloc_cnt got %0d exp 4", o_ldq_cnt);
        end
        tick();
        checks++;
        if (o_ret_vld !== 4'b0000) begin
            errors++;
            $display("FAIL alloc_no_ret got %b exp 0000", o_ret_vld);
        end
    endtask

    task automatic test_commit_pair();
        commit(2'b11, 5'd1, 5'd0);
        tick();
        idle();
        checks++;
        if (o_ret_vld !== 4'b0000) begin
            errors++;
            $display("FAIL pair_early got %b exp 0000", o_ret_vld);
        end
        tick();
        checks++;
        if (o_ret_vld !== 4'b0011 || o_ret_head_id !== 5'd0 || o_ldq_cnt !== 6'd2) begin
            errors++;
            $display("FAIL pair_ret got vld=%b head=%0d cnt=%0d exp 0011/0/2",
                     o_ret_vld, o_ret_head_id, o_ldq_cnt);
        end
        tick();
        checks++;
        if (o_ret_vld !== 4'b0000 || o_ldq_cnt !== 6'd2) begin
            errors++;
            $display("FAIL pair_pulse got vld=%b cnt=%0d exp 0000/2", o_ret_vld, o_ldq_cnt);
        end
    endtask

    task automatic test_in_order();
        commit(2'b01, 5'd3, 5'd0);
        tick();
        idle();
        tick();
        checks++;
        if (o_ret_vld !== 4'b0000) begin
            errors++;
            $display("FAIL order_hold got %b exp 0000", o_ret_vld);
        end
        commit(2'b10, 5'd0, 5'd2);
        tick();
        idle();
        checks++;
        if (o_ret_vld !== 4'b0000) begin
            errors++;
            $display("FAIL order_hold2 got %b exp 0000", o_ret_vld);
        end
        tick();
        checks++;
        if (o_ret_vld !== 4'b0011 || o_ret_head_id !== 5'd2 || o_ldq_cnt !== 6'd0) begin
            errors++;
            $display("FAIL order_ret got vld=%b head=%0d cnt=%0d exp 0011/2/0",
                     o_ret_vld, o_ret_head_id, o_ldq_cnt);
        end
    endtask

    task automatic test_wrap();
        for (int b = 4; b < 28; b += 4) batch(5'(b), 1'b1);
        batch(5'd28, 1'b0);
        checks++;
        if (o_ret_head_id !== 5'd30 || o_ldq_cnt !== 6'd0) begin
            errors++;
            $display("FAIL wrap_setup got head=%0d cnt=%0d exp 30/0", o_ret_head_id, o_ldq_cnt);
        end
        alloc(5'd30, 4'b1111);
        tick();
        alloc(5'd2, 4'b0011);
        tick();
        idle();
        checks++;
        if (o_ldq_cnt !== 6'd6) begin
            errors++;
            $display("FAIL wrap_cnt got %0d exp 6", o_ldq_cnt);
        end
        commit(2'b11, 5'd2, 5'd3);
        tick();
        commit(2'b11, 5'd0, 5'd1);
        tick();
        commit(2'b11, 5'd30, 5'd31);
        tick();
        idle();
        checks++;
        if (o_ret_vld !== 4'b0000) begin
            errors++;
            $display("FAIL wrap_wait got %b exp 0000", o_ret_vld);
        end
        tick();
        checks++;
        if (o_ret_vld !== 4'b1111 || o_ret_head_id !== 5'd30 || o_ldq_cnt !== 6'd2) begin
            errors++;
            $display("FAIL wrap_ret4 got vld=%b head=%0d cnt=%0d exp 1111/30/2",
                     o_ret_vld, o_ret_head_id, o_ldq_cnt);
        end
        tick();
        checks++;
        if (o_ret_vld !== 4'b0011 || o_ret_head_id !== 5'd2 || o_ldq_cnt !== 6'd0) begin
            errors++;
            $display("FAIL wrap_ret2 got vld=%b head=%0d cnt=%0d exp 0011/2/0",
                     o_ret_vld, o_ret_head_id, o_ldq_cnt);
        end
        tick();
        checks++;
        if (o_ret_vld !== 4'b0000 || o_ret_head_id !== 5'd4) begin
            errors++;
            $display("FAIL wrap_end got vld=%b head=%0d exp 0000/4", o_ret_vld, o_ret_head_id);
        end
    endtask

    task automatic test_mis_flush();
        rst = 1'b1;
        tick();
        idle();
        alloc(5'd0, 4'b1111);
        tick();
        alloc(5'd4, 4'b1111);
        tick();
        commit(2'b11, 5'd0, 5'd1);
        tick();
        idle();
        i_mis_flush = 1'b1;
        i_mis_ld_id = 5'd5;
        alloc(5'd8, 4'b1111);
        tick();
        idle();
        checks++;
        if (o_ret_vld !== 4'b0011 || o_ldq_cnt !== 6'd3) begin
            errors++;
            $display("FAIL mis_cnt got vld=%b cnt=%0d exp 0011/3", o_ret_vld, o_ldq_cnt);
        end
        alloc(5'd5, 4'b0001);
        tick();
        idle();
        checks++;
        if (o_ldq_cnt !== 6'd4) begin
            errors++;
            $display("FAIL mis_realloc got %0d exp 4", o_ldq_cnt);
        end
        commit(2'b11, 5'd2, 5'd3);
        tick();
        commit(2'b11, 5'd4, 5'd5);
        tick();
        idle();
        checks++;
        if (o_ret_vld !== 4'b0011 || o_ret_head_id !== 5'd2) begin
            errors++;
            $display("FAIL mis_ret1 got vld=%b head=%0d exp 0011/2", o_ret_vld, o_ret_head_id);
        end
        tick();
        checks++;
        if (o_ret_vld !== 4'b0011 || o_ret_head_id !== 5'd4 || o_ldq_cnt !== 6'd0) begin
            errors++;
            $display("FAIL mis_ret2 got vld=%b head=%0d cnt=%0d exp 0011/4/0",
                     o_ret_vld, o_ret_head_id, o_ldq_cnt);
        end
        tick();
    endtask

    task automatic test_trap_flush();
        alloc(5'd6, 4'b1111);
        tick();
        idle();
        commit(2'b11, 5'd6, 5'd7);
        tick();
        idle();
        i_csr_trap_flush = 1'b1;
        i_mis_flush      = 1'b1;
        i_mis_ld_id      = 5'd9;
        alloc(5'd10, 4'b1111);
        commit(2'b01, 5'd8, 5'd0);
        tick();
        idle();
        checks++;
        if (o_ret_vld !== 4'b0000 || o_ldq_cnt !== 6'd0 || o_ret_head_id !== 5'd0) begin
            errors++;
            $display("FAIL trap_state got vld=%b cnt=%0d head=%0d exp 0000/0/0",
                     o_ret_vld, o_ldq_cnt, o_ret_head_id);
        end
        alloc(5'd0, 4'b0001);
        tick();
        idle();
        commit(2'b01, 5'd0, 5'd0);
        tick();
        idle();
        tick();
        checks++;
        if (o_ret_vld !== 4'b0001 || o_ret_head_id !== 5'd0 || o_ldq_cnt !== 6'd0) begin
            errors++;
            $display("FAIL trap_restart got vld=%b head=%0d cnt=%0d exp 0001/0/0",
                     o_ret_vld, o_ret_head_id, o_ldq_cnt);
        end
        tick();
    endtask

    task automatic test_err();
        logic exp_err;
`ifdef LDQ_RET_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        checks++;
        if (o_ret_err !== 1'b0) begin
            errors++;
            $display("FAIL err_clean got %b exp 0", o_ret_err);
        end
        commit(2'b01, 5'd9, 5'd0);
        tick();
        idle();
        checks++;
        if (o_ret_err !== exp_err) begin
            errors++;
            $display("FAIL err_set got %b exp %b", o_ret_err, exp_err);
        end
        tick();
        tick();
        i_csr_trap_flush = 1'b1;
        tick();
        idle();
        checks++;
        if (o_ret_err !== exp_err) begin
            errors++;
            $display("FAIL err_sticky got %b exp %b", o_ret_err, exp_err);
        end
        rst = 1'b1;
        tick();
        idle();
        checks++;
        if (o_ret_err !== 1'b0) begin
            errors++;
            $display("FAIL err_rst got %b exp 0", o_ret_err);
        end
    endtask

    initial begin
        test_reset();
        test_alloc();
        test_commit_pair();
        test_in_order();
        test_wrap();
        test_mis_flush();
        test_trap_flush();
        test_err();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ldq_ret_ctrl.md
Name: ldq_ret_ctrl

Overview:
- In-order retirement controller for the 32-entry load-buffer ID pool.
- Tracks per-ID allocated/committed state and frees up to 4 oldest committed IDs per cycle.
- Its retire vector is the return-valid input of the dispatch load-ID allocator, so IDs re-enter the free pool strictly in allocation order.
- Handles trap flush (full reset of the pool) and misprediction rollback (squash from a given ID to the tail).

Parameters:
- LDQ_DEPTH, 32: number of load-buffer IDs; must be a power of two.
- ID_W, 5: ID width, log2(LDQ_DEPTH).
- RET_W, 4: maximum IDs retired per cycle.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- i_csr_trap_flush  in  1  clear entire pool.
- i_mis_flush  in  1  rollback; squash IDs from i_mis_ld_id to tail.
- i_mis_ld_id  in  ID_W  oldest squashed ID.
- i_alloc_vld  in  RET_W  per-slot allocation valids from dispatch.
- i_alloc_base_id  in  ID_W  ID of first allocated slot; following slots take base+prefix count of valids.
- i_cmt_vld  in  2  ROB load-commit valids, two ports.
- i_cmt_id_0, i_cmt_id_1  in  ID_W  committed load IDs.
- o_ret_vld  out  RET_W  thermometer retire vector (bit0 = oldest).
- o_ret_head_id  out  ID_W  head ID before this retire.
- o_ldq_cnt  out  ID_W+1  allocated, not-yet-retired count (0..32).
- o_ret_err  out  1  sticky protocol error (see Optional Feature).

Behaviour:
- State:
  - alloc_r[31:0] and done_r[31:0] bitmaps.
  - head_r and tail_r, ID_W bits each.
  - cnt_r, ID_W+1 bits.
  - o_ret_vld register.
- Reset (rst=1 at edge): all bitmaps 0, head_r=tail_r=0, cnt_r=0, o_ret_vld=0, o_ret_err=0.
- Allocation:
  - Slot k valid: set alloc_r[base + popcount(i_alloc_vld[k-1:0])] and clear its done bit.
  - tail_r += popcount(i_alloc_vld).
  - All arithmetic is modulo 32.
- Commit:
  - i_cmt_vld[p] sets done_r[i_cmt_id_p] only if alloc_r is set for that ID; otherwise the commit is ignored.
  - Both ports may commit in the same cycle.
- Retire:
  - Each edge, k = number of consecutive IDs starting at head_r with alloc & done set, capped at RET_W.
  - Register o_ret_vld = (1<<k)-1 and o_ret_head_id = head_r.
  - Clear alloc/done for those k IDs; head_r += k.
  - The window wraps: head=30, k=4 retires 30,31,0,1.
- Latency:
  - Commit sampled at edge N sets done_r.
  - Retire decision at edge N+1; o_ret_vld high during the cycle after edge N+1.
  - o_ret_vld is a single-cycle pulse per retire.
- Count: cnt_r_next = cnt_r + allocs − k − squashed. o_ldq_cnt = cnt_r.
- Mispredict flush (i_mis_flush=1):
  - Squash ID i when offset(i) >= offset(i_mis_ld_id) and offset(i) < cnt_r, where offset(x) = x − head_r mod 32.
  - Squashed IDs have alloc/done cleared; tail_r = i_mis_ld_id.
  - Allocations that cycle are ignored.
  - Commits and retire still apply; committed IDs are always older than the squash point.
  - If i_mis_ld_id == tail_r, nothing is squashed.
- Trap flush (i_csr_trap_flush=1):
  - Same effect as reset, except o_ret_err is kept.
  - Has priority over i_mis_flush, alloc and commit.
  - o_ret_vld=0 next cycle.
- Full/empty:
  - cnt_r==32: dispatch guarantees no allocation.
  - cnt_r==0: k=0 and o_ret_vld=0.
- Same-cycle events: alloc, commit and retire in one cycle are independent, since they touch disjoint IDs. Priority order is reset > trap flush > mispredict flush > alloc.

Optional Feature:
- Macro LDQ_RET_CHECK_EN.
- Defined: o_ret_err is set and held until rst when any of these occur:
  - a commit to an unallocated ID;
  - an allocation to an ID already allocated;
  - an allocation when cnt_r + allocs > 32.
- Not defined: the checking logic is absent and o_ret_err is tied 0. Functional behaviour is otherwise identical.

Test Plan:
- Reset, then allocate base=0, vld=4'b1111 → o_ldq_cnt=4; no o_ret_vld.
- Commit IDs 1 and 0 together → two cycles later o_ret_vld=4'b0011, head_id=0; o_ldq_cnt=2.
- Commit ID 3 only (2 not committed) → o_ret_vld stays 0; then commit 2 → o_ret_vld=4'b0011, head_id=2.
- Head at 30 with 6 IDs allocated, all committed → o_ret_vld=1111 (head_id=30), then o_ret_vld=0011 (head_id=2); head ends at 4 (wrap).
- 8 IDs allocated from 0 with 0..1 committed; mis flush with ID 5 → IDs 5..7 squashed; after retire o_ldq_cnt=3; next allocation uses base 5.
- Trap flush in the same cycle as alloc, commit and mis flush → next cycle head=tail=0, o_ldq_cnt=0, o_ret_vld=0. With LDQ_RET_CHECK_EN, a commit to unallocated ID 9 → o_ret_err=1 and sticky.
